// File: rtl/gpmc_pkg.sv
// Shared GPMC definitions: bus widths and the initiator FSM state encoding.
// Used by both the initiator (gpmc_master) and the responder side.
package gpmc_pkg;
   localparam int GPMC_ADR_W = 26;
   localparam int GPMC_DAT_W = 16;
   localparam int GPMC_A_W   = 10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ACCESS,
      ST_TURN
   } gpmc_state_t;
endpackage

// File: rtl/gpmc_clkgen.sv
// Divide-by-two GPMC clock generator; fall_tick marks the sys_clk edge on
// which gpmc_clk drops, i.e. the only edge where GPMC-side state may change.
module gpmc_clkgen (
   input  logic sys_clk,
   input  logic sys_rst,
   output logic gpmc_clk,
   output logic fall_tick
);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) gpmc_clk <= 1'b0;
      else         gpmc_clk <= ~gpmc_clk;
   end

   // gpmc_clk is high now, so the coming edge takes it 1 -> 0
   assign fall_tick = gpmc_clk;

endmodule

// File: rtl/gpmc_master.sv
// GPMC multiplexed address/data initiator: ADDR, ACCESS, TURN per request.
// Optional `GPMC_MASTER_WAIT_EN adds a synchronized gpmc_wait stall of ACCESS.
module gpmc_master
   import gpmc_pkg::*;
#(
   parameter int ACCESS_CYCLES = 4
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  req_stb,
   output logic                  req_ack,
   input  logic                  req_we,
   input  logic                  req_dma,
   input  logic [GPMC_ADR_W-1:0] req_adr,
   input  logic [GPMC_DAT_W-1:0] req_dat_w,
   output logic [GPMC_DAT_W-1:0] req_dat_r,
   output logic                  gpmc_clk,
   output logic [GPMC_A_W-1:0]   gpmc_a,
   output logic [GPMC_DAT_W-1:0] gpmc_d_o,
   output logic                  gpmc_d_oe,
   input  logic [GPMC_DAT_W-1:0] gpmc_d_i,
   output logic                  gpmc_ale_n,
   output logic                  gpmc_we_n,
   output logic                  gpmc_oe_n,
   output logic                  gpmc_csr_cs_n,
   output logic                  gpmc_dma_cs_n,
   input  logic                  gpmc_wait
);

   localparam logic [7:0] CNT_LOAD = 8'(ACCESS_CYCLES - 1);

   gpmc_state_t state;
   logic [7:0]  cnt;
   logic        fall_tick;
   logic        wait_sync;

   gpmc_clkgen u_clkgen (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .gpmc_clk  (gpmc_clk),
      .fall_tick (fall_tick)
   );

`ifdef GPMC_MASTER_WAIT_EN
   logic wait_s1, wait_s2;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wait_s1 <= 1'b0;
         wait_s2 <= 1'b0;
      end else begin
         wait_s1 <= gpmc_wait;
         wait_s2 <= wait_s1;
      end
   end

   assign wait_sync = wait_s2;
`else
   logic unused_wait;
   assign unused_wait = gpmc_wait;
   assign wait_sync   = 1'b0;
`endif

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         req_ack       <= 1'b0;
         req_dat_r     <= '0;
         gpmc_a        <= '0;
         gpmc_d_o      <= '0;
         gpmc_d_oe     <= 1'b0;
         gpmc_ale_n    <= 1'b1;
         gpmc_we_n     <= 1'b1;
         gpmc_oe_n     <= 1'b1;
         gpmc_csr_cs_n <= 1'b1;
         gpmc_dma_cs_n <= 1'b1;
      end else begin
         req_ack <= 1'b0;
         if (fall_tick) begin
            case (state)
               ST_IDLE: begin
                  if (req_stb) begin
                     state         <= ST_ADDR;
                     gpmc_ale_n    <= 1'b0;
                     gpmc_csr_cs_n <= req_dma;
                     gpmc_dma_cs_n <= ~req_dma;
                     gpmc_a        <= req_adr[GPMC_ADR_W-1:GPMC_DAT_W];
                     gpmc_d_o      <= req_adr[GPMC_DAT_W-1:0];
                     gpmc_d_oe     <= 1'b1;
                  end
               end
               // Bus direction flips here together with oe_n so the pad
               // never drives while the target is told to drive.
               ST_ADDR: begin
                  state      <= ST_ACCESS;
                  cnt        <= CNT_LOAD;
                  gpmc_ale_n <= 1'b1;
                  gpmc_we_n  <= ~req_we;
                  gpmc_oe_n  <= req_we;
                  gpmc_d_oe  <= req_we;
                  if (req_we) gpmc_d_o <= req_dat_w;
               end
               ST_ACCESS: begin
                  if (cnt != 8'd0) begin
                     cnt <= cnt - 8'd1;
                  end else if (!wait_sync) begin
                     state         <= ST_TURN;
                     gpmc_we_n     <= 1'b1;
                     gpmc_oe_n     <= 1'b1;
                     gpmc_csr_cs_n <= 1'b1;
                     gpmc_dma_cs_n <= 1'b1;
                     gpmc_d_oe     <= 1'b0;
                     if (!req_we) req_dat_r <= gpmc_d_i;
                  end
               end
               ST_TURN: begin
                  state   <= ST_IDLE;
                  req_ack <= 1'b1;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gpmc_master.sv
// Self-checking bench for gpmc_master: random and directed requests compared
// cycle by cycle against a phase-timeline model of the GPMC transaction.
module tb_gpmc_master;

   localparam int AC = 4;

   typedef struct packed {
      logic        clk;
      logic        ale;
      logic        we;
      logic        oe;
      logic        csr;
      logic        dma;
      logic        doe;
      logic        ack;
      logic [9:0]  a;
      logic [15:0] d;
   } bus_t;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        req_stb, req_we, req_dma;
   logic [25:0] req_adr;
   logic [15:0] req_dat_w, req_dat_r;
   logic        req_ack;
   logic        gpmc_clk, gpmc_d_oe, gpmc_ale_n, gpmc_we_n, gpmc_oe_n;
   logic        gpmc_csr_cs_n, gpmc_dma_cs_n, gpmc_wait;
   logic [9:0]  gpmc_a;
   logic [15:0] gpmc_d_o, gpmc_d_i;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [15:0] last_rd;
   bus_t        q_act[$];
   bus_t        q_exp[$];

   gpmc_master #(.ACCESS_CYCLES(AC)) dut (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .req_stb       (req_stb),
      .req_ack       (req_ack),
      .req_we        (req_we),
      .req_dma       (req_dma),
      .req_adr       (req_adr),
      .req_dat_w     (req_dat_w),
      .req_dat_r     (req_dat_r),
      .gpmc_clk      (gpmc_clk),
      .gpmc_a        (gpmc_a),
      .gpmc_d_o      (gpmc_d_o),
      .gpmc_d_oe     (gpmc_d_oe),
      .gpmc_d_i      (gpmc_d_i),
      .gpmc_ale_n    (gpmc_ale_n),
      .gpmc_we_n     (gpmc_we_n),
      .gpmc_oe_n     (gpmc_oe_n),
      .gpmc_csr_cs_n (gpmc_csr_cs_n),
      .gpmc_dma_cs_n (gpmc_dma_cs_n),
      .gpmc_wait     (gpmc_wait)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      #1;
      cyc++;
   endtask

   function automatic bus_t sample();
      bus_t s;
      s.clk = gpmc_clk;   s.ale = gpmc_ale_n;    s.we  = gpmc_we_n;
      s.oe  = gpmc_oe_n;  s.csr = gpmc_csr_cs_n; s.dma = gpmc_dma_cs_n;
      s.doe = gpmc_d_oe;  s.ack = req_ack;       s.a   = gpmc_a;
      s.d   = gpmc_d_o;
      return s;
   endfunction

   function automatic bus_t reset_bus();
      bus_t r;
      r = '0;
      r.ale = 1'b1; r.we = 1'b1; r.oe = 1'b1; r.csr = 1'b1; r.dma = 1'b1;
      return r;
   endfunction

   // One request: the model places every sys_clk edge in a phase by its
   // offset k from the accepting fall tick and records expected vs actual.
   task automatic drive_req(input logic we, input logic dma, input logic [25:0] adr,
                            input logic [15:0] dat, input logic [15:0] rd_val,
                            input int w, input bit wait_on, input bit keep);
      int   acc, k, kend, kack, ex;
      bus_t e, a;
      req_stb = 1'b1; req_we = we; req_dma = dma; req_adr = adr; req_dat_w = dat;
      acc  = (cyc % 2 == 0) ? cyc + 2 : cyc + 1;
      kend = 2 + 2 * (AC + w);
      kack = kend + 2;
      ex   = acc + 2 + 2 * AC;
      do begin
         tick();
         k = cyc - acc;
         e = reset_bus();
         e.clk = (cyc % 2 == 1);
         if (k >= 0 && k < kend) begin
            if (dma) e.dma = 1'b0; else e.csr = 1'b0;
            e.a = adr[25:16];
         end
         if (k >= 0 && k < 2) begin
            e.ale = 1'b0; e.d = adr[15:0]; e.doe = 1'b1;
         end else if (k >= 2 && k < kend) begin
            if (we) begin e.we = 1'b0; e.d = dat; e.doe = 1'b1; end
            else e.oe = 1'b0;
         end
         e.ack = (k == kack);
         a = sample();
         if (!(k >= 0 && k < kend)) a.a = '0;
         if (!((k >= 0 && k < 2) || (we && k >= 2 && k < kend))) a.d = '0;
         q_act.push_back(a);
         q_exp.push_back(e);
         gpmc_d_i  = (k == kend - 1) ? rd_val : 16'($urandom);
         gpmc_wait = wait_on && (cyc >= ex - 3) && (cyc <= ex + 2);
      end while (k < kack);
      gpmc_wait = 1'b0;
      if (!we) last_rd = rd_val;
      if (!keep) req_stb = 1'b0;
   endtask

   task automatic test_reset();
      bus_t r;
      r = reset_bus();
      checks++;
      if (sample() !== r) begin
         errors++;
         $display("FAIL reset_bus got %h expected %h", sample(), r);
      end
      checks++;
      if (req_dat_r !== 16'h0) begin
         errors++;
         $display("FAIL reset_dat_r got %h expected 0000", req_dat_r);
      end
      sys_rst = 1'b0;
      cyc = 0;
      last_rd = 16'h0;
   endtask

   task automatic test_write();
      drive_req(1'b1, 1'b0, 26'h1234567, 16'hBEEF, 16'h0, 0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         drive_req(1'b1, 1'($urandom), 26'($urandom), 16'($urandom), 16'h0, 0, 1'b0, 1'b0);
      foreach (q_exp[i]) begin
         checks++;
         if (q_act[i] !== q_exp[i]) begin
            errors++;
            $display("FAIL write[%0d] got %h expected %h", i, q_act[i], q_exp[i]);
         end
      end
      q_act.delete(); q_exp.delete();
      checks++;
      if (req_dat_r !== last_rd) begin
         errors++;
         $display("FAIL write_dat_r_hold got %h expected %h", req_dat_r, last_rd);
      end
   endtask

   task automatic test_read();
      drive_req(1'b0, 1'b1, 26'($urandom), 16'($urandom), 16'hA5C3, 0, 1'b0, 1'b0);
      checks++;
      if (req_dat_r !== 16'hA5C3) begin
         errors++;
         $display("FAIL read_dat_r got %h expected a5c3", req_dat_r);
      end
      for (int i = 0; i < 3; i++) begin
         drive_req(1'b0, 1'($urandom), 26'($urandom), 16'($urandom), 16'($urandom), 0, 1'b0, 1'b0);
         checks++;
         if (req_dat_r !== last_rd) begin
            errors++;
            $display("FAIL read_dat_r[%0d] got %h expected %h", i, req_dat_r, last_rd);
         end
      end
      foreach (q_exp[i]) begin
         checks++;
         if (q_act[i] !== q_exp[i]) begin
            errors++;
            $display("FAIL read[%0d] got %h expected %h", i, q_act[i], q_exp[i]);
         end
      end
      q_act.delete(); q_exp.delete();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++)
         drive_req(1'($urandom), 1'(i % 2), 26'($urandom), 16'($urandom), 16'($urandom),
                   0, 1'b0, i != 2);
      foreach (q_exp[i]) begin
         checks++;
         if (q_act[i] !== q_exp[i]) begin
            errors++;
            $display("FAIL b2b[%0d] got %h expected %h", i, q_act[i], q_exp[i]);
         end
      end
      q_act.delete(); q_exp.delete();
      checks++;
      if (req_dat_r !== last_rd) begin
         errors++;
         $display("FAIL b2b_dat_r got %h expected %h", req_dat_r, last_rd);
      end
   endtask

   task automatic test_wait();
      int w;
`ifdef GPMC_MASTER_WAIT_EN
      w = 3;
`else
      w = 0;
`endif
      drive_req(1'b1, 1'b0, 26'($urandom), 16'($urandom), 16'h0, w, 1'b1, 1'b0);
      drive_req(1'b0, 1'b1, 26'($urandom), 16'($urandom), 16'h3C5A, w, 1'b1, 1'b0);
      foreach (q_exp[i]) begin
         checks++;
         if (q_act[i] !== q_exp[i]) begin
            errors++;
            $display("FAIL wait[%0d] got %h expected %h", i, q_act[i], q_exp[i]);
         end
      end
      q_act.delete(); q_exp.delete();
      checks++;
      if (req_dat_r !== 16'h3C5A) begin
         errors++;
         $display("FAIL wait_dat_r got %h expected 3c5a", req_dat_r);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         drive_req(1'($urandom), 1'($urandom), 26'($urandom), 16'($urandom),
                   16'($urandom), 0, 1'b0, 1'b0);
         checks++;
         if (req_dat_r !== last_rd) begin
            errors++;
            $display("FAIL random_dat_r[%0d] got %h expected %h", i, req_dat_r, last_rd);
         end
      end
      foreach (q_exp[i]) begin
         checks++;
         if (q_act[i] !== q_exp[i]) begin
            errors++;
            $display("FAIL random[%0d] got %h expected %h", i, q_act[i], q_exp[i]);
         end
      end
      q_act.delete(); q_exp.delete();
   endtask

   task automatic test_reset_mid();
      int   acc;
      bus_t r;
      r = reset_bus();
      req_stb = 1'b1; req_we = 1'b1; req_dma = 1'($urandom);
      req_adr = 26'($urandom); req_dat_w = 16'($urandom);
      acc = (cyc % 2 == 0) ? cyc + 2 : cyc + 1;
      while (cyc < acc + 5) tick();
      sys_rst = 1'b1;
      #1;
      checks++;
      if (sample() !== r || req_dat_r !== 16'h0) begin
         errors++;
         $display("FAIL midreset_immediate got %h/%h expected %h/0000", sample(), req_dat_r, r);
      end
      req_stb = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (sample() !== r) begin
            errors++;
            $display("FAIL midreset_hold[%0d] got %h expected %h", i, sample(), r);
         end
      end
      sys_rst = 1'b0;
      cyc = 0;
      last_rd = 16'h0;
      drive_req(1'b0, 1'($urandom), 26'($urandom), 16'($urandom), 16'h9D2E, 0, 1'b0, 1'b0);
      foreach (q_exp[i]) begin
         checks++;
         if (q_act[i] !== q_exp[i]) begin
            errors++;
            $display("FAIL midreset_reissue[%0d] got %h expected %h", i, q_act[i], q_exp[i]);
         end
      end
      q_act.delete(); q_exp.delete();
      checks++;
      if (req_dat_r !== 16'h9D2E) begin
         errors++;
         $display("FAIL midreset_dat_r got %h expected 9d2e", req_dat_r);
      end
   endtask

   initial begin
      sys_rst = 1'b1; req_stb = 1'b0; req_we = 1'b0; req_dma = 1'b0;
      req_adr = '0; req_dat_w = '0; gpmc_d_i = '0; gpmc_wait = 1'b0;
      last_rd = 16'h0;
      repeat (3) tick();
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_wait();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
